// File: rtl/braille_char_sink_if.sv
// Character stream from the classifier plus the actuator/status outputs of the braille sink.
// master = classifier/observer side, slave = braille_char_sink.
interface braille_char_sink_if #(
  parameter int unsigned FIFO_DEPTH = 4
);
  localparam int unsigned LVL_W = $clog2(FIFO_DEPTH) + 1;

  logic             i_valid;
  logic [7:0]       i_alpha;
  logic [5:0]       o_dots;
  logic             o_busy;
  logic             o_char_done;
  logic             o_code_err;
  logic             o_overflow;
  logic [LVL_W-1:0] o_level;

  modport master (
    output i_valid,
    output i_alpha,
    input  o_dots,
    input  o_busy,
    input  o_char_done,
    input  o_code_err,
    input  o_overflow,
    input  o_level
  );

  modport slave (
    input  i_valid,
    input  i_alpha,
    output o_dots,
    output o_busy,
    output o_char_done,
    output o_code_err,
    output o_overflow,
    output o_level
  );
endinterface

// File: rtl/braille_char_sink.sv
// Queues ASCII letters from the classifier and plays each one as a 6-dot braille cell
// for HOLD_CYCLES, followed by an all-zero gap of GAP_CYCLES. Never back-pressures.
module braille_char_sink #(
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned HOLD_CYCLES = 50_000_000,
  parameter int unsigned GAP_CYCLES  = 10_000_000,
  parameter int unsigned CNT_BW      = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  braille_char_sink_if.slave   bus
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned PW = AW + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_HOLD = 2'd2,
    S_GAP  = 2'd3
  } state_e;

  // Returns {supported, dots}; uppercase A-J folds onto lowercase.
  function automatic logic [6:0] map_code(input logic [7:0] code);
    logic [7:0] lc;
    logic [6:0] res;
    lc = ((code >= 8'h41) && (code <= 8'h4A)) ? (code | 8'h20) : code;
    case (lc)
      8'h20:   res = {1'b1, 6'h00};
      8'h61:   res = {1'b1, 6'h01};
      8'h62:   res = {1'b1, 6'h03};
      8'h63:   res = {1'b1, 6'h09};
      8'h64:   res = {1'b1, 6'h19};
      8'h65:   res = {1'b1, 6'h11};
      8'h66:   res = {1'b1, 6'h0B};
      8'h67:   res = {1'b1, 6'h1B};
      8'h68:   res = {1'b1, 6'h13};
      8'h69:   res = {1'b1, 6'h0A};
      8'h6A:   res = {1'b1, 6'h1A};
      default: res = 7'h00;
    endcase
    return res;
  endfunction

  state_e            state_q, state_d;
  logic [CNT_BW-1:0] cnt_q, cnt_d;
  logic [7:0]        char_q, char_d;
  logic [5:0]        dots_q, dots_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              ovf_q, ovf_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [7:0]        mem_q [FIFO_DEPTH];

  logic [PW-1:0]     level;
  logic              full;
  logic              empty;
  logic              pop;
  logic              push;
  logic [7:0]        head;
  logic [6:0]        head_map;
  logic [6:0]        char_map;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign level    = wr_ptr_q - rd_ptr_q;
  assign full     = (level == PW'(FIFO_DEPTH));
  assign empty    = (level == '0);
  assign pop      = (state_q == S_IDLE) && !empty;
  assign push     = bus.i_valid && (!full || pop);
  assign head     = mem_q[rd_ptr_q[AW-1:0]];
  assign head_map = map_code(head);
  assign char_map = map_code(char_q);

  assign wr_ptr_d = wr_ptr_q + PW'(push);
  assign rd_ptr_d = rd_ptr_q + PW'(pop);
  assign ovf_d    = ovf_q | (bus.i_valid && full && !pop);

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= bus.i_alpha;
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    char_d  = char_q;
    dots_d  = dots_q;
    err_d   = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (pop) begin
          char_d  = head;
          err_d   = !head_map[6];
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        if (char_map[6]) begin
          dots_d  = char_map[5:0];
          cnt_d   = CNT_BW'(HOLD_CYCLES - 1);
          state_d = S_HOLD;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_HOLD: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_BW'(1);
        end else begin
          dots_d  = 6'h00;
          cnt_d   = CNT_BW'(GAP_CYCLES - 1);
          state_d = S_GAP;
        end
      end
      S_GAP: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_BW'(1);
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Registered pulse lands on the final hold cycle itself.
    done_d = (state_d == S_HOLD) && (cnt_d == '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      char_q   <= '0;
      dots_q   <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      ovf_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      char_q   <= char_d;
      dots_q   <= dots_d;
      done_q   <= done_d;
      err_q    <= err_d;
      ovf_q    <= ovf_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  assign bus.o_dots      = dots_q;
  assign bus.o_char_done = done_q;
  assign bus.o_code_err  = err_q;
  assign bus.o_overflow  = ovf_q;
  assign bus.o_level     = level;
  assign bus.o_busy      = (state_q != S_IDLE) || !empty;

endmodule
